// File: rtl/lbus_tx_arbiter.sv
// lbus_tx_arbiter
// Packet-granular round-robin merge of PORTS LBUS source streams onto one LBUS
// sink. A granted port keeps the sink until its open packet closes on a word
// boundary. One registered output stage; TX_RDY reaches the granted source's
// RX_RDY combinationally.
//
// Ports
//   CLK, RESET                      clock, synchronous active-high reset
//   RX_DATA/ENA/SOP/EOP/ERR/MTY     per-port source words, port i at slice i
//   RX_RDY                          per-port accept (combinational)
//   TX_DATA/ENA/SOP/EOP/ERR/MTY     merged output word (registered)
//   TX_RDY                          sink ready
//   GRANT, GRANT_VLD                granted port index, high while locked
module lbus_tx_arbiter #(
    parameter int unsigned PORTS     = 2,
    parameter int unsigned SEGMENTS  = 4,
    parameter int unsigned SEG_WIDTH = 128,
    localparam int unsigned GW       = (PORTS > 1) ? $clog2(PORTS) : 1
) (
    input  logic                                CLK,
    input  logic                                RESET,
    input  logic [PORTS*SEGMENTS*SEG_WIDTH-1:0] RX_DATA,
    input  logic [PORTS*SEGMENTS-1:0]           RX_ENA,
    input  logic [PORTS*SEGMENTS-1:0]           RX_SOP,
    input  logic [PORTS*SEGMENTS-1:0]           RX_EOP,
    input  logic [PORTS*SEGMENTS-1:0]           RX_ERR,
    input  logic [PORTS*SEGMENTS*4-1:0]         RX_MTY,
    output logic [PORTS-1:0]                    RX_RDY,
    output logic [SEGMENTS*SEG_WIDTH-1:0]       TX_DATA,
    output logic [SEGMENTS-1:0]                 TX_ENA,
    output logic [SEGMENTS-1:0]                 TX_SOP,
    output logic [SEGMENTS-1:0]                 TX_EOP,
    output logic [SEGMENTS-1:0]                 TX_ERR,
    output logic [SEGMENTS*4-1:0]               TX_MTY,
    input  logic                                TX_RDY,
    output logic [GW-1:0]                       GRANT,
    output logic                                GRANT_VLD
);

    localparam int unsigned WW = SEGMENTS * SEG_WIDTH;
    localparam int unsigned MW = SEGMENTS * 4;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [GW-1:0]      grant_q, grant_d;
    logic [GW-1:0]      rr_q, rr_d;
    logic [GW-1:0]      idx;
    logic               in_pkt_q, in_pkt_d;
    logic               pkt_open;
    logic               found;
    logic [PORTS-1:0]   req;
    logic [WW-1:0]      sel_data;
    logic [SEGMENTS-1:0] sel_ena, sel_sop, sel_eop, sel_err;
    logic [MW-1:0]      sel_mty;
    logic               locked;
    logic               load_en;
    logic               src_xfer;

    assign locked    = (state_q == LOCKED);
    assign load_en   = ~(|TX_ENA) | TX_RDY;
    assign src_xfer  = locked & (|sel_ena) & load_en;
    assign GRANT     = grant_q;
    assign GRANT_VLD = locked;

    // Per-port word valid and the granted port's word
    always_comb begin
        req      = '0;
        sel_data = '0;
        sel_ena  = '0;
        sel_sop  = '0;
        sel_eop  = '0;
        sel_err  = '0;
        sel_mty  = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            req[p] = |RX_ENA[p*SEGMENTS +: SEGMENTS];
            if (GW'(p) == grant_q) begin
                sel_data = RX_DATA[p*WW +: WW];
                sel_ena  = RX_ENA[p*SEGMENTS +: SEGMENTS];
                sel_sop  = RX_SOP[p*SEGMENTS +: SEGMENTS];
                sel_eop  = RX_EOP[p*SEGMENTS +: SEGMENTS];
                sel_err  = RX_ERR[p*SEGMENTS +: SEGMENTS];
                sel_mty  = RX_MTY[p*MW +: MW];
            end
        end
    end

    // Only the granted port sees ready, and only when the output can load
    always_comb begin
        RX_RDY = '0;
        for (int unsigned p = 0; p < PORTS; p++) begin
            RX_RDY[p] = locked & (GW'(p) == grant_q) & load_en;
        end
    end

    // Packet-open state after this word: segments in order, SOP before EOP
    always_comb begin
        pkt_open = in_pkt_q;
        for (int unsigned s = 0; s < SEGMENTS; s++) begin
            if (sel_ena[s] & sel_sop[s]) pkt_open = 1'b1;
            if (sel_ena[s] & sel_eop[s]) pkt_open = 1'b0;
        end
    end

    // Next-state logic: round-robin pick in IDLE, release on closed packet
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        rr_d     = rr_q;
        in_pkt_d = in_pkt_q;
        found    = 1'b0;
        idx      = '0;
        case (state_q)
            IDLE: begin
                for (int unsigned k = 0; k < PORTS; k++) begin
                    idx = GW'((32'(rr_q) + k) % PORTS);
                    if (!found && req[idx]) begin
                        found   = 1'b1;
                        grant_d = idx;
                        state_d = LOCKED;
                    end
                end
            end
            LOCKED: begin
                if (src_xfer) begin
                    in_pkt_d = pkt_open;
                    if (!pkt_open) begin
                        state_d = IDLE;
                        rr_d    = (grant_q == GW'(PORTS - 1)) ? '0 : grant_q + GW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Arbitration state registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_q     <= '0;
            in_pkt_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_q     <= rr_d;
            in_pkt_q <= in_pkt_d;
        end
    end

    // Output stage: load on transfer, bubble when empty-and-loadable, else hold
    always_ff @(posedge CLK) begin
        if (RESET) begin
            TX_DATA <= '0;
            TX_ENA  <= '0;
            TX_SOP  <= '0;
            TX_EOP  <= '0;
            TX_ERR  <= '0;
            TX_MTY  <= '0;
        end else if (load_en) begin
            if (src_xfer) begin
                TX_DATA <= sel_data;
                TX_ENA  <= sel_ena;
                TX_SOP  <= sel_sop;
                TX_EOP  <= sel_eop;
                TX_ERR  <= sel_err;
                TX_MTY  <= sel_mty;
            end else begin
                TX_ENA  <= '0;
                TX_SOP  <= '0;
                TX_EOP  <= '0;
                TX_ERR  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_lbus_tx_arbiter.sv
`timescale 1ns/1ps
// Bench for lbus_tx_arbiter: a PORTS=2 and a PORTS=4 instance, each fed by
// queued LBUS sources and compared every cycle against a packet-level model.
module tb_lbus_tx_arbiter;

    localparam int S  = 4;
    localparam int W  = 32;
    localparam int DW = S * W;
    localparam int MW = S * 4;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [S-1:0]  ena;
        logic [S-1:0]  sop;
        logic [S-1:0]  eop;
        logic [S-1:0]  err;
        logic [MW-1:0] mty;
    } word_t;

    logic CLK    = 1'b0;
    logic RESET  = 1'b1;
    logic tx_rdy = 1'b1;
    logic chk_en = 1'b0;
    always #5 CLK = ~CLK;

    // flattened source buses, index 0 = PORTS=2 instance, 1 = PORTS=4 instance
    logic [4*DW-1:0] r_data [2];
    logic [4*S-1:0]  r_ena  [2];
    logic [4*S-1:0]  r_sop  [2];
    logic [4*S-1:0]  r_eop  [2];
    logic [4*S-1:0]  r_err  [2];
    logic [4*MW-1:0] r_mty  [2];
    logic [1:0]      rdy2;
    logic [3:0]      rdy4;
    logic [DW-1:0]   t_data [2];
    logic [S-1:0]    t_ena  [2];
    logic [S-1:0]    t_sop  [2];
    logic [S-1:0]    t_eop  [2];
    logic [S-1:0]    t_err  [2];
    logic [MW-1:0]   t_mty  [2];
    logic [0:0]      g2;
    logic [1:0]      g4;
    logic            gv     [2];

    lbus_tx_arbiter #(.PORTS(2), .SEGMENTS(S), .SEG_WIDTH(W)) dut2 (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(r_data[0][2*DW-1:0]), .RX_ENA(r_ena[0][2*S-1:0]),
        .RX_SOP(r_sop[0][2*S-1:0]), .RX_EOP(r_eop[0][2*S-1:0]),
        .RX_ERR(r_err[0][2*S-1:0]), .RX_MTY(r_mty[0][2*MW-1:0]),
        .RX_RDY(rdy2),
        .TX_DATA(t_data[0]), .TX_ENA(t_ena[0]), .TX_SOP(t_sop[0]),
        .TX_EOP(t_eop[0]), .TX_ERR(t_err[0]), .TX_MTY(t_mty[0]),
        .TX_RDY(tx_rdy), .GRANT(g2), .GRANT_VLD(gv[0])
    );

    lbus_tx_arbiter #(.PORTS(4), .SEGMENTS(S), .SEG_WIDTH(W)) dut4 (
        .CLK(CLK), .RESET(RESET),
        .RX_DATA(r_data[1]), .RX_ENA(r_ena[1]), .RX_SOP(r_sop[1]),
        .RX_EOP(r_eop[1]), .RX_ERR(r_err[1]), .RX_MTY(r_mty[1]),
        .RX_RDY(rdy4),
        .TX_DATA(t_data[1]), .TX_ENA(t_ena[1]), .TX_SOP(t_sop[1]),
        .TX_EOP(t_eop[1]), .TX_ERR(t_err[1]), .TX_MTY(t_mty[1]),
        .TX_RDY(tx_rdy), .GRANT(g4), .GRANT_VLD(gv[1])
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int uid    = 0;
    int np [2] = '{2, 4};

    // sources: per instance/port word lists with a head pointer
    word_t src [2][4][24];
    int    hd  [2][4];
    int    ln  [2][4];
    logic  pop [2][4];
    word_t bus [2][4];

    // observed sink transfers
    int    lg_n    [2];
    int    lg_port [2][64];
    int    lg_id   [2][64];
    int    lg_cyc  [2][64];
    word_t lg_w    [2][64];

    // model state
    logic  m_locked [2];
    int    m_grant  [2];
    int    m_rr     [2];
    logic  m_inpkt  [2];
    word_t m_tx     [2];

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", nm, cyc, act, exp);
        end
    endtask

    function automatic logic dut_rdy(int k, int p);
        if (k == 0) return rdy2[p];
        return rdy4[p];
    endfunction

    function automatic int dut_grant(int k);
        if (k == 0) return int'(g2);
        return int'(g4);
    endfunction

    function automatic word_t dut_tx(int k);
        word_t w;
        w.data = t_data[k];
        w.ena  = t_ena[k];
        w.sop  = t_sop[k];
        w.eop  = t_eop[k];
        w.err  = t_err[k];
        w.mty  = t_mty[k];
        return w;
    endfunction

    // whether a packet is still open after this word, given the state before it
    function automatic logic open_after(logic open, word_t w);
        logic o;
        o = open;
        for (int s = 0; s < S; s++) begin
            if (w.ena[s] && w.sop[s]) o = 1'b1;
            if (w.ena[s] && w.eop[s]) o = 1'b0;
        end
        return o;
    endfunction

    task automatic drive_bus();
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) begin
                bus[k][p] = (hd[k][p] < ln[k][p]) ? src[k][p][hd[k][p]] : '0;
                r_data[k][p*DW +: DW] = bus[k][p].data;
                r_ena[k][p*S +: S]    = bus[k][p].ena;
                r_sop[k][p*S +: S]    = bus[k][p].sop;
                r_eop[k][p*S +: S]    = bus[k][p].eop;
                r_err[k][p*S +: S]    = bus[k][p].err;
                r_mty[k][p*MW +: MW]  = bus[k][p].mty;
            end
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
        for (int k = 0; k < 2; k++) begin
            for (int p = 0; p < 4; p++) begin
                if (pop[k][p] && hd[k][p] < ln[k][p]) hd[k][p]++;
                pop[k][p] = 1'b0;
            end
        end
        drive_bus();
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    // ks = 0: both instances (ports 0..1 only on the 2-port one), ks = 1: 4-port only
    task automatic send(int ks, int p, logic [3:0] ena, logic [3:0] sop, logic [3:0] eop,
                        int mty, logic [3:0] err);
        word_t w;
        w     = '0;
        w.ena = ena;
        w.sop = sop;
        w.eop = eop;
        w.err = err;
        for (int s = 0; s < S; s++) begin
            w.data[s*W +: W] = {8'(p), 8'(uid), 8'(s), 8'hC3};
            if (eop[s]) w.mty[s*4 +: 4] = 4'(mty);
        end
        uid++;
        for (int k = 0; k < 2; k++) begin
            if ((k == 1 || ks == 0) && p < np[k]) begin
                src[k][p][ln[k][p]] = w;
                ln[k][p]++;
            end
        end
    endtask

    task automatic flush();
        for (int k = 0; k < 2; k++)
            for (int p = 0; p < 4; p++) hd[k][p] = ln[k][p];
        drive_bus();
    endtask

    // ports of the logged packets from n0, expected ports packed as hex nibbles
    task automatic chk_order(string nm, int k, int n0, int cnt, int code);
        chk({nm, "_count"}, lg_n[k] - n0, cnt);
        for (int i = 0; i < cnt; i++) begin
            if (n0 + i < lg_n[k])
                chk($sformatf("%s_port%0d", nm, i), lg_port[k][n0 + i],
                    (code >> (4 * (cnt - 1 - i))) & 15);
        end
    endtask

    task automatic chk_idle_outputs(string nm);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("%s_i%0d_tx_ena", nm, k), t_ena[k], 0);
            chk($sformatf("%s_i%0d_rx_rdy", nm, k), (k == 0) ? 4'(rdy2) : rdy4, 0);
            chk($sformatf("%s_i%0d_grant_vld", nm, k), gv[k], 0);
            chk($sformatf("%s_i%0d_grant", nm, k), dut_grant(k), 0);
        end
    endtask

    // Per-cycle compare against the model, sink logging, source pops, model step
    always @(negedge CLK) begin
        word_t a, e, w;
        logic load, found;
        logic [3:0] er, ar;
        int p;
        cyc++;
        for (int k = 0; k < 2; k++) begin
            load = (m_tx[k].ena == '0) || tx_rdy;
            er = '0;
            ar = '0;
            for (int q = 0; q < np[k]; q++) begin
                er[q] = m_locked[k] && (m_grant[k] == q) && load;
                ar[q] = dut_rdy(k, q);
            end
            if (chk_en) begin
                a = dut_tx(k);
                e = m_tx[k];
                chk($sformatf("i%0d_rx_rdy", k), ar, er);
                chk($sformatf("i%0d_tx_ena", k), a.ena, e.ena);
                if (e.ena != '0) begin
                    chk($sformatf("i%0d_tx_data", k), a.data, e.data);
                    chk($sformatf("i%0d_tx_sop", k), a.sop, e.sop);
                    chk($sformatf("i%0d_tx_eop", k), a.eop, e.eop);
                    chk($sformatf("i%0d_tx_err", k), a.err, e.err);
                    chk($sformatf("i%0d_tx_mty", k), a.mty, e.mty);
                end
                chk($sformatf("i%0d_grant", k), dut_grant(k), m_grant[k]);
                chk($sformatf("i%0d_grant_vld", k), gv[k], m_locked[k]);
                if (a.ena != '0 && tx_rdy && lg_n[k] < 64) begin
                    lg_port[k][lg_n[k]] = int'(a.data[31:24]);
                    lg_id[k][lg_n[k]]   = int'(a.data[23:16]);
                    lg_cyc[k][lg_n[k]]  = cyc;
                    lg_w[k][lg_n[k]]    = a;
                    lg_n[k]++;
                end
            end
            for (int q = 0; q < np[k]; q++) pop[k][q] = ar[q] && (bus[k][q].ena != '0);

            if (RESET) begin
                m_locked[k] = 1'b0;
                m_grant[k]  = 0;
                m_rr[k]     = 0;
                m_inpkt[k]  = 1'b0;
                m_tx[k]     = '0;
            end else if (m_locked[k]) begin
                w = bus[k][m_grant[k]];
                if (load) begin
                    if (w.ena != '0) begin
                        m_tx[k]    = w;
                        m_inpkt[k] = open_after(m_inpkt[k], w);
                        if (!m_inpkt[k]) begin
                            m_locked[k] = 1'b0;
                            m_rr[k]     = (m_grant[k] + 1) % np[k];
                        end
                    end else begin
                        m_tx[k] = '0;
                    end
                end
            end else begin
                if (load) m_tx[k] = '0;
                found = 1'b0;
                for (int j = 0; j < np[k]; j++) begin
                    p = (m_rr[k] + j) % np[k];
                    if (!found && bus[k][p].ena != '0) begin
                        found       = 1'b1;
                        m_grant[k]  = p;
                        m_locked[k] = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int n0, n4, id0;
        for (int k = 0; k < 2; k++) begin
            lg_n[k] = 0;
            for (int p = 0; p < 4; p++) begin
                hd[k][p]  = 0;
                ln[k][p]  = 0;
                pop[k][p] = 1'b0;
            end
        end
        drive_bus();
        run(2);
        RESET  = 1'b0;
        chk_en = 1'b1;
        chk_idle_outputs("reset");

        // single 3-word packet on port 0, MTY 5 on the EOP segment
        n0 = lg_n[0];
        send(0, 0, 4'hF, 4'b0001, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b0000, 0, 4'h0);
        send(0, 0, 4'b0111, 4'b0000, 4'b0100, 5, 4'h0);
        run(10);
        chk_order("single", 0, n0, 3, 'h000);
        if (lg_n[0] >= n0 + 3) begin
            chk("single_mty_seg2", lg_w[0][n0 + 2].mty[11:8], 5);
            chk("single_eop", lg_w[0][n0 + 2].eop, 4'b0100);
            chk("single_sop", lg_w[0][n0].sop, 4'b0001);
        end
        chk("single_grant", g2, 0);
        chk("single_released", gv[0], 0);

        // round-robin pointer now at 1: simultaneous requests serve port 1 first
        n0 = lg_n[0];
        send(0, 0, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        send(0, 1, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        run(8);
        chk_order("rr_after_single", 0, n0, 2, 'h10);

        // contention from a clean reset: strict alternation with one bubble each
        RESET = 1'b1;
        run(1);
        RESET = 1'b0;
        n0 = lg_n[0];
        send(0, 0, 4'hF, 4'b0001, 4'b1000, 1, 4'h0);
        send(0, 1, 4'hF, 4'b0001, 4'b1000, 2, 4'h0);
        send(0, 0, 4'hF, 4'b0001, 4'b1000, 3, 4'h0);
        send(0, 1, 4'hF, 4'b0001, 4'b1000, 4, 4'h0);
        run(12);
        chk_order("contention", 0, n0, 4, 'h0101);
        if (lg_n[0] >= n0 + 4) begin
            for (int i = 0; i < 3; i++)
                chk($sformatf("contention_gap%0d", i),
                    lg_cyc[0][n0 + i + 1] - lg_cyc[0][n0 + i], 2);
        end

        // backpressure mid-packet: 6-word packet, sink stalled for 5 cycles
        n0  = lg_n[0];
        id0 = uid;
        send(0, 0, 4'hF, 4'b0001, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b0000, 0, 4'b0010);
        send(0, 0, 4'hF, 4'b0000, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b1000, 2, 4'h0);
        for (int c = 0; c < 20; c++) begin
            tx_rdy = !(c >= 3 && c <= 7);
            tick();
            if (c >= 3 && c <= 7) begin
                chk($sformatf("stall_rx_rdy_c%0d", c), rdy2, 2'b00);
                chk($sformatf("stall_tx_ena_c%0d", c), t_ena[0], 4'hF);
            end
        end
        tx_rdy = 1'b1;
        chk("bp_count", lg_n[0] - n0, 6);
        for (int i = 0; i < 6; i++) begin
            if (n0 + i < lg_n[0]) chk($sformatf("bp_seq%0d", i), lg_id[0][n0 + i], (id0 + i) & 255);
        end

        // straddle word on port 1 keeps the grant while port 0 waits
        n0 = lg_n[0];
        send(0, 1, 4'hF, 4'b0001, 4'b0000, 0, 4'h0);
        send(0, 1, 4'hF, 4'b0100, 4'b0010, 7, 4'h0);
        send(0, 1, 4'hF, 4'b0000, 4'b0000, 0, 4'h0);
        send(0, 1, 4'b0001, 4'b0000, 4'b0001, 3, 4'h0);
        run(2);
        send(0, 0, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        run(3);
        chk("straddle_grant_held", g2, 1);
        run(9);
        chk_order("straddle", 0, n0, 5, 'h11110);

        // reset while word 2 of a 4-word packet is presented
        send(0, 0, 4'hF, 4'b0001, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b0000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0000, 4'b1000, 0, 4'h0);
        run(3);
        RESET = 1'b1;
        tick();
        chk_idle_outputs("mid_reset");
        RESET = 1'b0;
        flush();
        n0 = lg_n[0];
        send(0, 1, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        send(0, 0, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        run(8);
        chk_order("after_reset", 0, n0, 2, 'h01);

        // four-port wrap: last grant 3, then 0 and 2, then 3 ahead of 1
        n4 = lg_n[1];
        send(1, 3, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        run(6);
        send(1, 2, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        send(1, 0, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        run(8);
        send(1, 1, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        send(1, 3, 4'hF, 4'b0001, 4'b1000, 0, 4'h0);
        run(8);
        chk_order("wrap4", 1, n4, 5, 'h30231);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
